// File: rtl/cbrt_pkg.sv
// Shared definitions for the iterative integer cube-root block.
package cbrt_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam int DEFAULT_WIDTH_IN  = 24;
   localparam int DEFAULT_WIDTH_OUT = DEFAULT_WIDTH_IN / 3;

endpackage

// File: rtl/cbrt_step.sv
// One restoring digit step of the cube root: tries to append a 1 to the partial root y
// and subtracts the matching cube increment from the partial remainder x.
module cbrt_step #(
   parameter int WIDTH_IN  = 24,
   parameter int WIDTH_OUT = WIDTH_IN / 3,
   parameter int SW        = $clog2(WIDTH_IN)
) (
   input  logic [WIDTH_IN-1:0]  x_i,
   input  logic [WIDTH_OUT-1:0] y_i,
   input  logic [SW-1:0]        s_i,
   output logic [WIDTH_IN-1:0]  x_o,
   output logic [WIDTH_OUT-1:0] y_o
);

   localparam int WB = WIDTH_IN + 2;
   localparam int PW = 2 * WIDTH_OUT + 2;

   logic [WIDTH_OUT:0]    y2;
   logic [WIDTH_OUT:0]    y2p1;
   logic [PW-1:0]         prod;
   logic [WB-1:0]         b;
   logic [WB-1:0]         xs;
   logic [2*WIDTH_IN-1:0] bsh;
   logic                  take;

   // b = 3*y2*(y2+1) + 1 is the increase of (2y+1)^3 over (2y)^3; the compare runs
   // two bits wider than the operand so it never truncates.
   always_comb begin
      y2   = {y_i, 1'b0};
      y2p1 = y2 + (WIDTH_OUT + 1)'(1);
      prod = PW'(y2) * PW'(y2p1);
      b    = WB'(prod) + (WB'(prod) << 1) + WB'(1);
      xs   = WB'(x_i >> s_i);
      take = (xs >= b);
      bsh  = (2 * WIDTH_IN)'(b) << s_i;
      x_o  = take ? (x_i - WIDTH_IN'(bsh)) : x_i;
      y_o  = WIDTH_OUT'({y_i, take});
   end

endmodule

// File: rtl/cube_root_iter.sv
// Iterative integer cube root: root = floor(cbrt(din)), rem = din - root^3,
// one result bit per cycle behind a start/busy/done handshake.
module cube_root_iter
   import cbrt_pkg::*;
#(
   parameter int WIDTH_IN = DEFAULT_WIDTH_IN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH_IN-1:0]     din,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH_IN/3-1:0]   root,
   output logic [WIDTH_IN-1:0]     rem
);

   localparam int WIDTH_OUT = WIDTH_IN / 3;
   localparam int SW        = $clog2(WIDTH_IN);
   localparam int CW        = $clog2(WIDTH_OUT + 1);

   localparam logic [SW-1:0] S_INIT    = SW'(WIDTH_IN - 3);
   localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH_OUT);

   if (WIDTH_IN % 3 != 0) begin : g_bad_width
      $error("cube_root_iter: WIDTH_IN must be a multiple of 3");
   end

   state_e                 state_q;
   logic                   busy_q;
   logic                   done_q;
   logic [WIDTH_OUT-1:0]   root_q;
   logic [WIDTH_IN-1:0]    rem_q;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH_IN-1:0]    x_q;
   logic [WIDTH_OUT-1:0]   y_q;
   logic [SW-1:0]          s_q;
   logic [WIDTH_IN-1:0]    x_d;
   logic [WIDTH_OUT-1:0]   y_d;

   cbrt_step #(
      .WIDTH_IN  (WIDTH_IN),
      .WIDTH_OUT (WIDTH_OUT),
      .SW        (SW)
   ) u_step (
      .x_i (x_q),
      .y_i (y_q),
      .s_i (s_q),
      .x_o (x_d),
      .y_o (y_d)
   );

   // After the last step the FSM spends one more RUN cycle publishing y/x to root/rem,
   // so the outputs never move mid-operation. DONE accepts a new start directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         root_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         s_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  x_q     <= din;
                  y_q     <= '0;
                  s_q     <= S_INIT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  root_q  <= y_q;
                  rem_q   <= x_q;
               end else begin
                  x_q   <= x_d;
                  y_q   <= y_d;
                  s_q   <= s_q - SW'(3);
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign root = root_q;
   assign rem  = rem_q;

endmodule

// File: tb/tb_cube_root_iter.sv
// Scoreboard bench for cube_root_iter: the driver queues expected results, a monitor
// compares them whenever done pulses.
module tb_cube_root_iter;

   localparam int WIDTH_IN  = 24;
   localparam int WIDTH_OUT = WIDTH_IN / 3;
   localparam int TIMEOUT   = 60;

   typedef struct {
      logic [WIDTH_IN-1:0]  n;
      logic [WIDTH_OUT-1:0] root;
      logic [WIDTH_IN-1:0]  rem;
   } expect_t;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [WIDTH_IN-1:0]  din;
   logic                 busy;
   logic                 done;
   logic [WIDTH_OUT-1:0] root;
   logic [WIDTH_IN-1:0]  rem;

   expect_t scoreboard[$];
   int      totalCount;
   int      badCount;

   cube_root_iter #(.WIDTH_IN(WIDTH_IN)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .root  (root),
      .rem   (rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalCount++;
      if (actual !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Brute-force reference: largest r with r^3 <= n.
   task automatic refCbrt(input logic [WIDTH_IN-1:0] n, output logic [WIDTH_OUT-1:0] r,
                          output logic [WIDTH_IN-1:0] rm);
      longint k;
      k = 0;
      while ((k + 1) * (k + 1) * (k + 1) <= longint'(n)) k++;
      r  = WIDTH_OUT'(k);
      rm = WIDTH_IN'(longint'(n) - k * k * k);
   endtask

   task automatic startOp(input logic [WIDTH_IN-1:0] n);
      @(negedge clk);
      start = 1'b1;
      din   = n;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(output int edges, output bit ok);
      edges = 0;
      ok    = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         totalCount++;
         badCount++;
         $display("[TB] FAIL doneTimeout: got no done within %0d cycles, expected a pulse", TIMEOUT);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH_IN-1:0] n, input logic [WIDTH_OUT-1:0] r,
                                input logic [WIDTH_IN-1:0] rm, output int latency);
      expect_t e;
      bit      ok;
      e.n = n;
      e.root = r;
      e.rem = rm;
      scoreboard.push_back(e);
      startOp(n);
      waitDone(latency, ok);
      if (!ok) void'(scoreboard.pop_back());
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (scoreboard.size() == 0) begin
               totalCount++;
               badCount++;
               $display("[TB] FAIL unexpectedDone: got done with root=%0d rem=%0d, expected no pulse",
                        root, rem);
            end else begin
               e = scoreboard.pop_front();
               checkOutput($sformatf("root(N=%0d)", e.n), 32'(root), 32'(e.root));
               checkOutput($sformatf("rem(N=%0d)", e.n), 32'(rem), 32'(e.rem));
            end
         end
      end
   end

   initial begin
      int                   lat;
      int                   gap;
      bit                   ok;
      logic [WIDTH_IN-1:0]  n;
      logic [WIDTH_OUT-1:0] r;
      logic [WIDTH_IN-1:0]  rm;

      totalCount = 0;
      badCount   = 0;
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetRoot", 32'(root), 32'd0);
      checkOutput("resetRem", 32'(rem), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(24'd27, 8'd3, 24'd0, lat);
      checkOutput("latency27", 32'(lat), 32'(WIDTH_OUT + 1));
      applyStimulus(24'd26, 8'd2, 24'd18, lat);
      applyStimulus(24'd0, 8'd0, 24'd0, lat);
      applyStimulus(24'd16777215, 8'd255, 24'd195840, lat);
      applyStimulus(24'd1860867, 8'd123, 24'd0, lat);

      // start while busy must be ignored; outputs hold the previous result during RUN
      begin
         expect_t e;
         e.n = 24'd1000;
         e.root = 8'd10;
         e.rem = 24'd0;
         scoreboard.push_back(e);
      end
      startOp(24'd1000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      din   = 24'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busyDuringRun", 32'(busy), 32'd1);
      checkOutput("rootHeldInRun", 32'(root), 32'd123);
      checkOutput("remHeldInRun", 32'(rem), 32'd0);
      waitDone(lat, ok);
      if (!ok) void'(scoreboard.pop_back());
      repeat (15) @(posedge clk);

      // reset mid-operation aborts without a done pulse
      startOp(24'd1000);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortRoot", 32'(root), 32'd0);
      checkOutput("abortRem", 32'(rem), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(posedge clk);
      applyStimulus(24'd64, 8'd4, 24'd0, lat);

      // back-to-back: start held through DONE
      begin
         expect_t e;
         e.n = 24'd125;
         e.root = 8'd5;
         e.rem = 24'd0;
         scoreboard.push_back(e);
         e.n = 24'd343;
         e.root = 8'd7;
         scoreboard.push_back(e);
      end
      @(negedge clk);
      start = 1'b1;
      din   = 24'd125;
      @(posedge clk);
      #1;
      din = 24'd343;
      waitDone(lat, ok);
      checkOutput("latency125", 32'(lat), 32'(WIDTH_OUT + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(lat, ok);
      gap = lat + 1;
      checkOutput("backToBackGap", 32'(gap), 32'(WIDTH_OUT + 2));

      for (int i = 0; i < 8; i++) begin
         n = WIDTH_IN'($urandom);
         refCbrt(n, r, rm);
         applyStimulus(n, r, rm, lat);
      end

      repeat (3) @(posedge clk);
      checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
